// File: rtl/l2_fwd_stall_buffer_if.sv
// Interface for the L2 forward stall buffer: fwd handler capture, MSHR frees,
// decoder consume, and the held-forward outputs.
interface l2_fwd_stall_buffer_if #(
    parameter int unsigned REQS_IDX_BITS  = 2,
    parameter int unsigned LINE_ADDR_BITS = 28,
    parameter int unsigned MSG_BITS       = 5,
    parameter int unsigned ID_BITS        = 4,
    parameter int unsigned CNT_BITS       = 16
);
    logic                      stall_capture;
    logic [LINE_ADDR_BITS-1:0] stall_fwd_addr;
    logic [MSG_BITS-1:0]       stall_fwd_msg;
    logic [ID_BITS-1:0]        stall_fwd_id;
    logic [REQS_IDX_BITS-1:0]  stall_mshr_idx;
    logic                      mshr_free_valid;
    logic [REQS_IDX_BITS-1:0]  mshr_free_idx;
    logic                      set_fwd_in_from_stalled;

    logic                      fwd_stall;
    logic                      fwd_stall_ended;
    logic [LINE_ADDR_BITS-1:0] fwd_stalled_addr;
    logic [MSG_BITS-1:0]       fwd_stalled_msg;
    logic [ID_BITS-1:0]        fwd_stalled_id;
    logic [CNT_BITS-1:0]       stall_cycles;
    logic                      stall_overflow;

    modport master (
        output stall_capture, stall_fwd_addr, stall_fwd_msg, stall_fwd_id, stall_mshr_idx,
        output mshr_free_valid, mshr_free_idx, set_fwd_in_from_stalled,
        input  fwd_stall, fwd_stall_ended, fwd_stalled_addr, fwd_stalled_msg, fwd_stalled_id,
        input  stall_cycles, stall_overflow
    );

    modport slave (
        input  stall_capture, stall_fwd_addr, stall_fwd_msg, stall_fwd_id, stall_mshr_idx,
        input  mshr_free_valid, mshr_free_idx, set_fwd_in_from_stalled,
        output fwd_stall, fwd_stall_ended, fwd_stalled_addr, fwd_stalled_msg, fwd_stalled_id,
        output stall_cycles, stall_overflow
    );
endinterface

// File: rtl/l2_fwd_stall_buffer.sv
// Holds one forward blocked by an in-flight MSHR entry and releases it for replay
// once that entry frees; the decoder consumes it when it is ready.
module l2_fwd_stall_buffer #(
    parameter int unsigned N_REQS         = 4,
    parameter int unsigned REQS_IDX_BITS  = 2,
    parameter int unsigned LINE_ADDR_BITS = 28,
    parameter int unsigned MSG_BITS       = 5,
    parameter int unsigned ID_BITS        = 4,
    parameter int unsigned CNT_BITS       = 16
) (
    input logic                    clk,
    input logic                    rst,
    l2_fwd_stall_buffer_if.slave   bus
);
    typedef enum logic [1:0] {StIdle, StStalled, StEnded} state_e;

    state_e                    state;
    logic                      fwd_stall;
    logic                      fwd_stall_ended;
    logic [LINE_ADDR_BITS-1:0] held_addr;
    logic [MSG_BITS-1:0]       held_msg;
    logic [ID_BITS-1:0]        held_id;
    logic [REQS_IDX_BITS-1:0]  held_idx;
    logic [CNT_BITS-1:0]       stall_cycles;
    logic                      stall_overflow;

    logic capture_ok;
    logic capture_blocked;
    logic free_new;
    logic free_held;

    // A capture is only accepted into an empty buffer, or into one being consumed this cycle.
    always_comb begin
        capture_ok      = bus.stall_capture &&
                          (state == StIdle || (state == StEnded && bus.set_fwd_in_from_stalled));
        capture_blocked = bus.stall_capture && !capture_ok;
        free_new        = bus.mshr_free_valid && (bus.mshr_free_idx == bus.stall_mshr_idx);
        free_held       = bus.mshr_free_valid && (bus.mshr_free_idx == held_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= StIdle;
            fwd_stall       <= 1'b0;
            fwd_stall_ended <= 1'b0;
            held_addr       <= '0;
            held_msg        <= '0;
            held_id         <= '0;
            held_idx        <= '0;
            stall_cycles    <= '0;
            stall_overflow  <= 1'b0;
        end else begin
            if (capture_ok) begin
                held_addr    <= bus.stall_fwd_addr;
                held_msg     <= bus.stall_fwd_msg;
                held_id      <= bus.stall_fwd_id;
                held_idx     <= bus.stall_mshr_idx;
                stall_cycles <= '0;
                fwd_stall    <= 1'b1;
                if (free_new) begin
                    state           <= StEnded;
                    fwd_stall_ended <= 1'b1;
                end else begin
                    state           <= StStalled;
                    fwd_stall_ended <= 1'b0;
                end
            end else begin
                unique case (state)
                    StStalled: begin
                        if (stall_cycles != '1) begin
                            stall_cycles <= stall_cycles + CNT_BITS'(1);
                        end
                        if (free_held) begin
                            state           <= StEnded;
                            fwd_stall_ended <= 1'b1;
                        end
                    end
                    StEnded: begin
                        if (bus.set_fwd_in_from_stalled) begin
                            state           <= StIdle;
                            fwd_stall       <= 1'b0;
                            fwd_stall_ended <= 1'b0;
                        end
                    end
                    default: begin
                        state           <= StIdle;
                        fwd_stall       <= 1'b0;
                        fwd_stall_ended <= 1'b0;
                    end
                endcase
            end
            if (capture_blocked) begin
                stall_overflow <= 1'b1;
            end
        end
    end

    assign bus.fwd_stall        = fwd_stall;
    assign bus.fwd_stall_ended  = fwd_stall_ended;
    assign bus.fwd_stalled_addr = held_addr;
    assign bus.fwd_stalled_msg  = held_msg;
    assign bus.fwd_stalled_id   = held_id;
    assign bus.stall_cycles     = stall_cycles;
    assign bus.stall_overflow   = stall_overflow;
endmodule

// File: tb/tb_l2_fwd_stall_buffer.sv
// Directed bench for l2_fwd_stall_buffer; expected outputs are queued per step
// and compared after the clock edge that should produce them.
module tb_l2_fwd_stall_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    l2_fwd_stall_buffer_if bus ();

    l2_fwd_stall_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        stall;
        logic        ended;
        logic [27:0] addr;
        logic [4:0]  msg;
        logic [3:0]  id;
        logic [15:0] cyc;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic stall, input logic ended, input logic [27:0] addr,
                                input logic [4:0] msg, input logic [3:0] id,
                                input logic [15:0] cyc, input logic ovf);
        exp_t e;
        e.tag   = "";
        e.stall = stall;
        e.ended = ended;
        e.addr  = addr;
        e.msg   = msg;
        e.id    = id;
        e.cyc   = cyc;
        e.ovf   = ovf;
        return e;
    endfunction

    task automatic drv(input logic cap, input logic [27:0] addr, input logic [4:0] msg,
                       input logic [3:0] id, input logic [1:0] idx, input logic fv,
                       input logic [1:0] fidx, input logic cons);
        bus.stall_capture           = cap;
        bus.stall_fwd_addr          = addr;
        bus.stall_fwd_msg           = msg;
        bus.stall_fwd_id            = id;
        bus.stall_mshr_idx          = idx;
        bus.mshr_free_valid         = fv;
        bus.mshr_free_idx           = fidx;
        bus.set_fwd_in_from_stalled = cons;
    endtask

    task automatic idle_in();
        drv(1'b0, 28'h0, 5'h0, 4'h0, 2'd0, 1'b0, 2'd0, 1'b0);
    endtask

    // Push the expectation, clock once, then pop and compare away from the edge.
    task automatic step(input string tag, input exp_t e);
        exp_t x;
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk({x.tag, ".fwd_stall"},       {31'd0, bus.fwd_stall},       {31'd0, x.stall});
        chk({x.tag, ".fwd_stall_ended"}, {31'd0, bus.fwd_stall_ended}, {31'd0, x.ended});
        chk({x.tag, ".addr"},            {4'd0, bus.fwd_stalled_addr}, {4'd0, x.addr});
        chk({x.tag, ".msg"},             {27'd0, bus.fwd_stalled_msg}, {27'd0, x.msg});
        chk({x.tag, ".id"},              {28'd0, bus.fwd_stalled_id},  {28'd0, x.id});
        chk({x.tag, ".stall_cycles"},    {16'd0, bus.stall_cycles},    {16'd0, x.cyc});
        chk({x.tag, ".stall_overflow"},  {31'd0, bus.stall_overflow},  {31'd0, x.ovf});
    endtask

    localparam logic [27:0] A1 = 28'h0ABCDEF;
    localparam logic [27:0] A2 = 28'h1234567;
    localparam logic [27:0] A3 = 28'h0000001;
    localparam logic [27:0] A4 = 28'h0C0FFEE;
    localparam logic [27:0] A5 = 28'h0FFFFFF;
    localparam logic [27:0] A6 = 28'h5555555;

    initial begin
        idle_in();
        rst = 1'b1;
        step("reset", mk(0, 0, 28'h0, 5'h0, 4'h0, 16'd0, 0));
        rst = 1'b0;
        step("idle", mk(0, 0, 28'h0, 5'h0, 4'h0, 16'd0, 0));

        // Capture idx 2, free it three cycles later.
        drv(1'b1, A1, 5'h11, 4'h7, 2'd2, 1'b0, 2'd0, 1'b0);
        step("cap1", mk(1, 0, A1, 5'h11, 4'h7, 16'd0, 0));
        idle_in();
        step("st1_c1", mk(1, 0, A1, 5'h11, 4'h7, 16'd1, 0));
        step("st1_c2", mk(1, 0, A1, 5'h11, 4'h7, 16'd2, 0));
        drv(1'b0, 28'h0, 5'h0, 4'h0, 2'd0, 1'b1, 2'd2, 1'b0);
        step("free1", mk(1, 1, A1, 5'h11, 4'h7, 16'd3, 0));
        idle_in();
        step("ended1", mk(1, 1, A1, 5'h11, 4'h7, 16'd3, 0));
        drv(1'b0, 28'h0, 5'h0, 4'h0, 2'd0, 1'b0, 2'd0, 1'b1);
        step("consume1", mk(0, 0, A1, 5'h11, 4'h7, 16'd3, 0));
        idle_in();

        // Frees of a different index and consume while STALLED are ignored.
        drv(1'b1, A2, 5'h03, 4'h1, 2'd3, 1'b0, 2'd0, 1'b0);
        step("cap2", mk(1, 0, A2, 5'h03, 4'h1, 16'd0, 0));
        drv(1'b0, 28'h0, 5'h0, 4'h0, 2'd0, 1'b1, 2'd1, 1'b0);
        step("wrong_free", mk(1, 0, A2, 5'h03, 4'h1, 16'd1, 0));
        drv(1'b0, 28'h0, 5'h0, 4'h0, 2'd0, 1'b0, 2'd0, 1'b1);
        step("early_consume", mk(1, 0, A2, 5'h03, 4'h1, 16'd2, 0));
        drv(1'b0, 28'h0, 5'h0, 4'h0, 2'd0, 1'b1, 2'd3, 1'b0);
        step("free2", mk(1, 1, A2, 5'h03, 4'h1, 16'd3, 0));
        drv(1'b0, 28'h0, 5'h0, 4'h0, 2'd0, 1'b0, 2'd0, 1'b1);
        step("consume2", mk(0, 0, A2, 5'h03, 4'h1, 16'd3, 0));

        // Capture and free of the same index in one cycle, then a long deferral.
        drv(1'b1, A3, 5'h01, 4'h2, 2'd0, 1'b1, 2'd0, 1'b0);
        step("cap_free_same", mk(1, 1, A3, 5'h01, 4'h2, 16'd0, 0));
        idle_in();
        for (int i = 0; i < 10; i++) begin
            step($sformatf("defer%0d", i), mk(1, 1, A3, 5'h01, 4'h2, 16'd0, 0));
        end
        drv(1'b0, 28'h0, 5'h0, 4'h0, 2'd0, 1'b0, 2'd0, 1'b1);
        step("consume3", mk(0, 0, A3, 5'h01, 4'h2, 16'd0, 0));

        // Consume and capture together replays the new forward into STALLED.
        drv(1'b1, A4, 5'h0A, 4'h3, 2'd1, 1'b0, 2'd0, 1'b0);
        step("cap4", mk(1, 0, A4, 5'h0A, 4'h3, 16'd0, 0));
        drv(1'b0, 28'h0, 5'h0, 4'h0, 2'd0, 1'b1, 2'd1, 1'b0);
        step("free4", mk(1, 1, A4, 5'h0A, 4'h3, 16'd1, 0));
        drv(1'b1, A5, 5'h1F, 4'hF, 2'd2, 1'b0, 2'd0, 1'b1);
        step("replay", mk(1, 0, A5, 5'h1F, 4'hF, 16'd0, 0));

        // Capture while STALLED sets sticky overflow and leaves the held data.
        drv(1'b1, A6, 5'h15, 4'h5, 2'd3, 1'b0, 2'd0, 1'b0);
        step("ovf_stalled", mk(1, 0, A5, 5'h1F, 4'hF, 16'd1, 1));
        idle_in();
        step("ovf_sticky", mk(1, 0, A5, 5'h1F, 4'hF, 16'd2, 1));

        // Reset mid-hold drops everything; a later free of the old index does nothing.
        rst = 1'b1;
        step("rst_mid", mk(0, 0, 28'h0, 5'h0, 4'h0, 16'd0, 0));
        rst = 1'b0;
        drv(1'b0, 28'h0, 5'h0, 4'h0, 2'd0, 1'b1, 2'd2, 1'b0);
        step("stale_free", mk(0, 0, 28'h0, 5'h0, 4'h0, 16'd0, 0));
        idle_in();
        step("post_rst", mk(0, 0, 28'h0, 5'h0, 4'h0, 16'd0, 0));

        // Capture in ENDED without consume also overflows.
        drv(1'b1, A2, 5'h06, 4'h9, 2'd0, 1'b1, 2'd0, 1'b0);
        step("cap6", mk(1, 1, A2, 5'h06, 4'h9, 16'd0, 0));
        drv(1'b1, A6, 5'h15, 4'h5, 2'd1, 1'b0, 2'd0, 1'b0);
        step("ovf_ended", mk(1, 1, A2, 5'h06, 4'h9, 16'd0, 1));
        idle_in();
        rst = 1'b1;
        step("rst_clears_ovf", mk(0, 0, 28'h0, 5'h0, 4'h0, 16'd0, 0));
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
